// File: rtl/freq_meter.sv
// Measures period and high time of an asynchronous square wave in clk_in cycles.
// Continuous measurement between consecutive rising edges, with a sticky no-edge timeout.
module freq_meter #(
  parameter int unsigned CLK_IN_F_MHZ   = 100,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_cycles,
  output logic [CNT_W-1:0] high_cycles,
  output logic             period_valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Reject parameter sets where the counter could wrap before the timeout fires.
  if (CLK_IN_F_MHZ == 0 || CNT_W == 0 ||
      (CNT_W < 32 && (TIMEOUT_CYCLES >> CNT_W) != 0)) begin : g_param_check
    $error("freq_meter: TIMEOUT_CYCLES must be below 2**CNT_W");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] period_d, high_d;
  logic             valid_d, timeout_d, busy_d;

  logic sync_1, sync_2, sync_prev;
  logic rise, fall;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= sig_in;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign rise = sync_2 & ~sync_prev;
  assign fall = ~sync_2 & sync_prev;

  // Next-state and datapath decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    period_d  = period_cycles;
    high_d    = high_cycles;
    valid_d   = 1'b0;
    timeout_d = timeout;

    if (!enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
        end
        ARM: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        MEASURE: begin
          if (fall) pend_d = cnt_q;
          // A rise on the timeout cycle wins: it is a legal period of exactly TIMEOUT_CYCLES.
          if (rise) begin
            period_d  = cnt_q;
            high_d    = pend_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = CNT_ONE;
          end else if (cnt_q == TIMEOUT_VAL) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ARM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d == MEASURE);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pend_q        <= '0;
      period_cycles <= '0;
      high_cycles   <= '0;
      period_valid  <= 1'b0;
      timeout       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      period_cycles <= period_d;
      high_cycles   <= high_d;
      period_valid  <= valid_d;
      timeout       <= timeout_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: expected pulses are queued as the wave is driven
// and compared by a monitor when period_valid fires; scenario tasks check state inline.
module tb_freq_meter;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned T     = 1000;

  logic             clk_in;
  logic             reset_n;
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] period_cycles;
  logic [CNT_W-1:0] high_cycles;
  logic             period_valid;
  logic             timeout;
  logic             busy;

  freq_meter #(
    .CLK_IN_F_MHZ  (100),
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .enable       (enable),
    .sig_in       (sig_in),
    .period_cycles(period_cycles),
    .high_cycles  (high_cycles),
    .period_valid (period_valid),
    .timeout      (timeout),
    .busy         (busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int unsigned p;
    int unsigned h;
    int unsigned gap;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_pulse = 0;
  int unsigned last_p = 0;
  int unsigned last_h = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Scoreboard monitor: every period_valid pulse must match the oldest queued expectation.
  always @(negedge clk_in) begin
    if (period_valid) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: period_cycles=%0d high_cycles=%0d, required no pulse",
                 period_cycles, high_cycles);
      end else begin
        e = exp_q.pop_front();
        if (period_cycles !== e.p) begin
          errors++;
          $display("FAIL pulse_period: got %0d required %0d", period_cycles, e.p);
        end
        checks++;
        if (high_cycles !== e.h) begin
          errors++;
          $display("FAIL pulse_high: got %0d required %0d", high_cycles, e.h);
        end
        if (e.gap != 0) begin
          checks++;
          if (cyc - last_pulse != e.gap) begin
            errors++;
            $display("FAIL pulse_spacing: got %0d required %0d", cyc - last_pulse, e.gap);
          end
        end
        last_p = e.p;
        last_h = e.h;
      end
      last_pulse = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    sig_in = v;
    tick(n);
  endtask

  task automatic run_wave(input int p, input int h, input int nrises);
    for (int i = 0; i < nrises; i++) begin
      drive(1'b1, h);
      drive(1'b0, p - h);
    end
  endtask

  task automatic push_exp(input int unsigned p, input int unsigned h, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{p, h, (i == 0) ? 0 : p});
  endtask

  task automatic recycle();
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    checks++;
    if ({period_cycles, high_cycles, period_valid, timeout, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got p=%0d h=%0d v=%b t=%b b=%b required all 0",
               period_cycles, high_cycles, period_valid, timeout, busy);
    end
    reset_n = 1'b1;
    tick(2);
    checks++;
    if ({period_cycles, high_cycles, period_valid, timeout, busy} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got p=%0d h=%0d v=%b t=%b b=%b required all 0",
               period_cycles, high_cycles, period_valid, timeout, busy);
    end
  endtask

  task automatic test_patterns();
    int unsigned pats[4][2] = '{'{10, 5}, '{2, 1}, '{7, 3}, '{13, 12}};
    for (int k = 0; k < 4; k++) begin
      recycle();
      push_exp(pats[k][0], pats[k][1], 5);
      run_wave(int'(pats[k][0]), int'(pats[k][1]), 6);
      tick(6);
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pattern_%0d_pulses: %0d pulses missing, required 0", k, exp_q.size());
        exp_q.delete();
      end
      checks++;
      if (busy !== 1'b1 || period_cycles !== pats[k][0] || high_cycles !== pats[k][1]) begin
        errors++;
        $display("FAIL pattern_%0d_hold: got b=%b p=%0d h=%0d required b=1 p=%0d h=%0d",
                 k, busy, period_cycles, high_cycles, pats[k][0], pats[k][1]);
      end
    end
  endtask

  task automatic test_timeout();
    recycle();
    drive(1'b1, T + 2);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b required 0", timeout);
    end
    tick(1);
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0 || period_cycles !== last_p || high_cycles !== last_h) begin
      errors++;
      $display("FAIL timeout_fire: got t=%b b=%b p=%0d h=%0d required t=1 b=0 p=%0d h=%0d",
               timeout, busy, period_cycles, high_cycles, last_p, last_h);
    end
    drive(1'b0, 5);
    run_wave(20, 8, 1);
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got t=%b b=%b required t=1 b=1", timeout, busy);
    end
    push_exp(20, 8, 2);
    run_wave(20, 8, 2);
    tick(6);
    checks++;
    if (timeout !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_clear: got t=%b pending=%0d required t=0 pending=0",
               timeout, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_priority();
    recycle();
    push_exp(T, 500, 1);
    drive(1'b1, 500);
    drive(1'b0, 500);
    drive(1'b1, 5);
    checks++;
    if (timeout !== 1'b0 || exp_q.size() != 0 || period_cycles !== T || busy !== 1'b1) begin
      errors++;
      $display("FAIL rise_at_timeout: got t=%0b p=%0d b=%b pending=%0d required t=0 p=%0d b=1 pending=0",
               timeout, period_cycles, busy, exp_q.size(), T);
      exp_q.delete();
    end
    drive(1'b0, 2);
  endtask

  task automatic test_enable_drop();
    recycle();
    push_exp(10, 5, 2);
    run_wave(10, 5, 3);
    enable = 1'b0;
    tick(1);
    checks++;
    if (busy !== 1'b0 || period_valid !== 1'b0 || period_cycles !== 10 || high_cycles !== 5 ||
        timeout !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL enable_drop: got b=%b v=%b p=%0d h=%0d t=%b pending=%0d required b=0 v=0 p=10 h=5 t=0 pending=0",
               busy, period_valid, period_cycles, high_cycles, timeout, exp_q.size());
      exp_q.delete();
    end
    run_wave(10, 5, 2);
    checks++;
    if (busy !== 1'b0 || period_cycles !== 10 || high_cycles !== 5) begin
      errors++;
      $display("FAIL disabled_hold: got b=%b p=%0d h=%0d required b=0 p=10 h=5",
               busy, period_cycles, high_cycles);
    end
    enable = 1'b1;
    tick(1);
    push_exp(9, 4, 2);
    run_wave(9, 4, 3);
    tick(6);
    checks++;
    if (exp_q.size() != 0 || period_cycles !== 9 || high_cycles !== 4) begin
      errors++;
      $display("FAIL reenable: got p=%0d h=%0d pending=%0d required p=9 h=4 pending=0",
               period_cycles, high_cycles, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    recycle();
    push_exp(12, 6, 2);
    run_wave(12, 6, 3);
    drive(1'b1, 1);
    #2;
    reset_n = 1'b0;
    sig_in  = 1'b0;
    #1;
    checks++;
    if ({period_cycles, high_cycles, period_valid, timeout, busy} !== '0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL async_reset: got p=%0d h=%0d v=%b t=%b b=%b pending=%0d required all 0",
               period_cycles, high_cycles, period_valid, timeout, busy, exp_q.size());
      exp_q.delete();
    end
    tick(2);
    reset_n = 1'b1;
    tick(1);
    push_exp(12, 6, 2);
    run_wave(12, 6, 3);
    tick(6);
    checks++;
    if (exp_q.size() != 0 || period_cycles !== 12 || high_cycles !== 6) begin
      errors++;
      $display("FAIL after_reset_rearm: got p=%0d h=%0d pending=%0d required p=12 h=6 pending=0",
               period_cycles, high_cycles, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    sig_in  = 1'b0;
    test_reset();
    test_patterns();
    test_timeout();
    test_priority();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 The block SHALL have parameter CLK_IN_F_MHZ, default 100, giving the clk_in frequency; it is informational only and does not change behaviour.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the counter and result registers.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 100_000_000, giving the number of cycles without a rising edge that raises timeout; legal only if TIMEOUT_CYCLES < 2^CNT_W.
REQ-004 clk_in  input  1  sole clock; all state is updated on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  measurement enable, synchronous to clk_in.
REQ-007 sig_in  input  1  square wave under measurement, asynchronous to clk_in (e.g. a divided clock).
REQ-008 period_cycles  output  CNT_W  clk_in cycles between the last two sig_in rising edges.
REQ-009 high_cycles  output  CNT_W  clk_in cycles sig_in was high within the last measured period.
REQ-010 period_valid  output  1  one-cycle pulse when period_cycles and high_cycles update.
REQ-011 timeout  output  1  sticky flag: no rising edge seen within TIMEOUT_CYCLES.
REQ-012 busy  output  1  high when the state machine is in state MEASURE.

Function
REQ-013 sig_in SHALL pass through a 2-flop synchronizer; a third flop SHALL hold the previous synchronized value for edge detection.
REQ-014 rise = sync & ~prev and fall = ~sync & prev; a sig_in transition SHALL be detected 3 clk_in cycles after it is sampled.
REQ-015 The state machine SHALL have three states: IDLE, ARM and MEASURE.
REQ-016 IDLE: if enable=1, go to ARM next cycle; otherwise stay in IDLE with cnt=0.
REQ-017 ARM: on rise, set cnt to 1 and go to MEASURE; otherwise hold cnt=0; no result is produced in ARM.
REQ-018 MEASURE: cnt SHALL increment by 1 every cycle without a rise.
REQ-019 MEASURE, on fall: high_cycles SHALL load the current cnt into a pending register; the published high_cycles updates only together with period_valid.
REQ-020 MEASURE, on rise: period_cycles <= cnt, high_cycles <= pending high, period_valid = 1 for one cycle, timeout <= 0, cnt <= 1, and the state stays MEASURE; measurement is continuous.
REQ-021 If rises are detected N cycles apart, period_cycles SHALL equal N; the minimum legal N is 2.
REQ-022 MEASURE: when cnt reaches TIMEOUT_CYCLES with no rise that cycle, set timeout <= 1, cnt <= 0 and go to ARM; period_cycles and high_cycles hold.
REQ-023 A rise in the same cycle that cnt equals TIMEOUT_CYCLES SHALL take priority (normal result, no timeout).
REQ-024 enable=0 in any state SHALL force IDLE next cycle, with cnt <= 0, timeout <= 0 and no period_valid; result registers hold.
REQ-025 A fall with no preceding rise in MEASURE is impossible by construction; a fall in ARM or IDLE SHALL be ignored.
REQ-026 cnt SHALL never wrap, because the timeout bound in REQ-003 keeps it below 2^CNT_W.

Reset
REQ-027 reset_n=0 SHALL asynchronously force: state IDLE, cnt 0, synchronizer and edge flops 0, period_cycles 0, high_cycles 0, pending high 0, period_valid 0, timeout 0.
REQ-028 After reset_n is released, the first rise SHALL only arm the block; the first period_valid needs two rises.
REQ-029 Asserting reset_n mid-measurement SHALL discard the partial count; no period_valid is emitted.

Verification
REQ-030 enable=1, sig_in period 10 cycles, high 5 -> period_valid every 10 cycles from the second rise; period_cycles=10, high_cycles=5.
REQ-031 sig_in toggling every clk_in cycle (period 2) -> period_cycles=2, high_cycles=1, period_valid every 2 cycles.
REQ-032 TIMEOUT_CYCLES=1000, sig_in stuck after one rise -> timeout=1 exactly 1000 cycles after that rise is detected, state ARM; a subsequent regular wave clears timeout on the next period_valid.
REQ-033 enable dropped mid-period -> busy=0 next cycle, no period_valid, results hold; re-enable needs two rises before the next period_valid.
REQ-034 reset_n pulsed low mid-period -> all outputs 0 immediately, asynchronously, without waiting for a clk_in edge.
REQ-035 Rise coinciding with cnt=TIMEOUT_CYCLES -> period_valid=1, period_cycles=TIMEOUT_CYCLES, timeout=0.
